// File: rtl/ccu_ax_scheduler.sv
// ccu_ax_scheduler: round-robin AR/AW address scheduler for the CCU.
// Grants one request at a time and holds the grant until ax_ready_i.
// A grant is refused to any port that already has MaxOutstanding
// transactions in flight. The R/B completion pulses release those slots.
// Optional feature macro: CCU_SCHED_STALL_CNT_EN adds the per-port
// stall cycle counters on stall_cnt_o. When it is undefined, stall_cnt_o is 0.
module ccu_ax_scheduler #(
    parameter int NoPorts        = 2,
    parameter int MaxOutstanding = 4,
    parameter int IdxW           = $clog2(NoPorts),
    parameter int CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NoPorts-1:0]      ar_valid_i,
    input  logic [NoPorts-1:0]      aw_valid_i,
    output logic [NoPorts-1:0]      ar_gnt_o,
    output logic [NoPorts-1:0]      aw_gnt_o,
    output logic [IdxW-1:0]         sel_idx_o,
    output logic                    sel_write_o,
    output logic                    gnt_valid_o,
    input  logic                    ax_ready_i,
    input  logic [NoPorts-1:0]      r_done_i,
    input  logic [NoPorts-1:0]      b_done_i,
    output logic [NoPorts-1:0]      full_o,
    output logic                    err_o,
    output logic [NoPorts*32-1:0]   stall_cnt_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [IdxW-1:0]     r_sel_idx;
    logic                r_sel_write;
    logic [IdxW-1:0]     r_rr_ptr;
    logic [NoPorts-1:0]  r_last_write;
    logic                r_err;

    logic [NoPorts-1:0]  w_req;
    logic [NoPorts-1:0]  w_elig;
    logic [NoPorts-1:0]  w_under;
    logic                w_any_elig;
    logic [IdxW-1:0]     w_win_idx;
    logic                w_win_write;
    logic                w_handshake;

    assign w_req       = ar_valid_i | aw_valid_i;
    assign w_elig      = w_req & ~full_o;
    assign w_handshake = (r_state == ST_GRANT) && ax_ready_i;

    // Winner is the first eligible port at or after the round-robin pointer.
    always_comb begin
        int cand;
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        w_any_elig = 1'b0;
        w_win_idx  = '0;
        cand       = 0;
        for (int i = 0; i < NoPorts; i++) begin
            cand = int'(r_rr_ptr) + i;
            if (cand >= NoPorts) begin
                cand = cand - NoPorts;
            end
            if (!w_any_elig && w_elig[IdxW'(cand)]) begin
                w_any_elig = 1'b1;
                w_win_idx  = IdxW'(cand);
            end
        end
    end

    // A lone AR or AW wins outright. If both are pending, the winner is the opposite of the port's last granted channel.
    assign w_win_write = aw_valid_i[w_win_idx]
                       & (~ar_valid_i[w_win_idx] | ~r_last_write[w_win_idx]);

    // Next-state logic: a grant is taken whenever anyone is eligible and released on the handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_elig) w_state_next = ST_GRANT;
            ST_GRANT: if (ax_ready_i) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Grant outputs decode the registered selection and are held at zero outside GRANT.
    always_comb begin
        ar_gnt_o    = '0;
        aw_gnt_o    = '0;
        sel_idx_o   = '0;
        sel_write_o = 1'b0;
        gnt_valid_o = 1'b0;
        if (r_state == ST_GRANT) begin
            gnt_valid_o = 1'b1;
            sel_idx_o   = r_sel_idx;
            sel_write_o = r_sel_write;
            if (r_sel_write) aw_gnt_o[r_sel_idx] = 1'b1;
            else             ar_gnt_o[r_sel_idx] = 1'b1;
        end
    end

    // State register, latched selection, fairness pointer and per-port channel history.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state      <= ST_IDLE;
            r_sel_idx    <= '0;
            r_sel_write  <= 1'b0;
            r_rr_ptr     <= '0;
            r_last_write <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && w_any_elig) begin
                r_sel_idx   <= w_win_idx;
                r_sel_write <= w_win_write;
            end
            if (w_handshake) begin
                r_rr_ptr <= (r_sel_idx == IdxW'(NoPorts - 1)) ? '0 : r_sel_idx + 1'b1;
                r_last_write[r_sel_idx] <= r_sel_write;
            end
        end
    end

    for (genvar p = 0; p < NoPorts; p++) begin : g_port
        logic [CntW-1:0] r_cnt;
        logic [CntW:0]   w_up;
        logic [CntW:0]   w_dn;

        assign w_up       = {1'b0, r_cnt} + (CntW + 1)'(w_handshake && (r_sel_idx == IdxW'(p)));
        assign w_dn       = (CntW + 1)'(r_done_i[p]) + (CntW + 1)'(b_done_i[p]);
        assign w_under[p] = w_up < w_dn;
        assign full_o[p]  = (r_cnt == CntW'(MaxOutstanding));

        // Outstanding counter: net change from the handshake and both completions, clamped at zero.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_cnt <= '0;
            end else if (w_under[p]) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= CntW'(w_up - w_dn);
            end
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (|w_under) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

`ifdef CCU_SCHED_STALL_CNT_EN
    for (genvar s = 0; s < NoPorts; s++) begin : g_stall
        logic [31:0] r_stall;

        // Count cycles with a pending request and no grant, saturating at all-ones.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_stall <= '0;
            end else if (w_req[s] && !(ar_gnt_o[s] || aw_gnt_o[s]) && (r_stall != '1)) begin
                r_stall <= r_stall + 32'd1;
            end
        end

        assign stall_cnt_o[s*32 +: 32] = r_stall;
    end
`else
    assign stall_cnt_o = '0;
`endif

    // A granted requester must keep its valid asserted until the handshake.
    a_valid_held : assert property (@(posedge clk_i) disable iff (rst_i)
        (r_state == ST_GRANT) |-> (r_sel_write ? aw_valid_i[r_sel_idx] : ar_valid_i[r_sel_idx]));

endmodule
